// File: rtl/csr_mtimer.sv
`default_nettype none
// ============================================================================
//  Module      : csr_mtimer
//  Description : 64-bit machine timer (mtime) with prescaler, compare register
//                (mtimecmp), level timer interrupt and a CSR_XLEN-wide
//                half-selectable read/write view of both registers.
//                Optional feature macro: TIMER_HI_LATCH_EN (tear-free hi read
//                via a shadow captured on mtime-lo reads, CSR_XLEN=32 only).
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_mtimer #(
    parameter int CSR_XLEN    = 32,  // 32 or 64
    parameter int CNT_WIDTH   = 64,  // must be 64
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [1:0]             sel_i,
    input  logic [CSR_XLEN-1:0]    wdata_i,
    output logic [CSR_XLEN-1:0]    rdata_o,
    output logic                   rvalid_o,
    output logic                   irq_o,
    output logic                   tick_o
);

    localparam int HALF = CNT_WIDTH / 2;

    logic [PRESC_WIDTH-1:0] r_presc;
    logic [CNT_WIDTH-1:0]   r_mtime;
    logic [CNT_WIDTH-1:0]   r_mtimecmp;

    logic                   w_tick;
    logic                   w_mtime_wr;
    logic                   w_cmp_wr;
    logic [CNT_WIDTH-1:0]   w_mtime_wdata;
    logic [CNT_WIDTH-1:0]   w_cmp_wdata;
    logic [CSR_XLEN-1:0]    w_rd_data;

    assign w_tick = en_i && (r_presc == presc_i);

    generate
        if (CSR_XLEN == 32) begin : g_xlen32
            assign w_mtime_wr = we_i && !sel_i[1];
            assign w_cmp_wr   = we_i &&  sel_i[1];

            // Replace the selected half, keep the other one
            always_comb begin
                w_mtime_wdata = r_mtime;
                w_cmp_wdata   = r_mtimecmp;
                if (sel_i[0]) begin
                    w_mtime_wdata[CNT_WIDTH-1:HALF] = wdata_i;
                    w_cmp_wdata[CNT_WIDTH-1:HALF]   = wdata_i;
                end else begin
                    w_mtime_wdata[HALF-1:0] = wdata_i;
                    w_cmp_wdata[HALF-1:0]   = wdata_i;
                end
            end

`ifdef TIMER_HI_LATCH_EN
            logic [HALF-1:0] r_hi_shadow;

            // Capture live mtime hi whenever mtime lo is read
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hi_shadow <= '0;
                end else if (re_i && (sel_i == 2'b00)) begin
                    r_hi_shadow <= r_mtime[CNT_WIDTH-1:HALF];
                end
            end

            // Read mux; mtime hi comes from the shadow
            always_comb begin
                w_rd_data = '0;
                case (sel_i)
                    2'b00:   w_rd_data = r_mtime[HALF-1:0];
                    2'b01:   w_rd_data = r_hi_shadow;
                    2'b10:   w_rd_data = r_mtimecmp[HALF-1:0];
                    default: w_rd_data = r_mtimecmp[CNT_WIDTH-1:HALF];
                endcase
            end
`else
            // Read mux; all values live
            always_comb begin
                w_rd_data = '0;
                case (sel_i)
                    2'b00:   w_rd_data = r_mtime[HALF-1:0];
                    2'b01:   w_rd_data = r_mtime[CNT_WIDTH-1:HALF];
                    2'b10:   w_rd_data = r_mtimecmp[HALF-1:0];
                    default: w_rd_data = r_mtimecmp[CNT_WIDTH-1:HALF];
                endcase
            end
`endif
        end else begin : g_xlen64
            // Odd selects are unused at full width: read 0, writes ignored
            assign w_mtime_wr    = we_i && (sel_i == 2'b00);
            assign w_cmp_wr      = we_i && (sel_i == 2'b10);
            assign w_mtime_wdata = wdata_i;
            assign w_cmp_wdata   = wdata_i;

            // Full-width read mux
            always_comb begin
                w_rd_data = '0;
                case (sel_i)
                    2'b00:   w_rd_data = r_mtime;
                    2'b10:   w_rd_data = r_mtimecmp;
                    default: w_rd_data = '0;
                endcase
            end
        end
    endgenerate

    // Prescaler, mtime and tick pulse; a mtime write overrides any tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_mtime <= '0;
            tick_o  <= 1'b0;
        end else begin
            if (w_mtime_wr) begin
                r_presc <= '0;
                r_mtime <= w_mtime_wdata;
            end else if (en_i) begin
                r_presc <= w_tick ? '0 : r_presc + PRESC_WIDTH'(1);
                if (w_tick) begin
                    r_mtime <= r_mtime + CNT_WIDTH'(1);
                end
            end
            tick_o <= w_tick && !w_mtime_wr;
        end
    end

    // Compare register and registered interrupt level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtimecmp <= '1;
            irq_o      <= 1'b0;
        end else begin
            if (w_cmp_wr) begin
                r_mtimecmp <= w_cmp_wdata;
            end
            irq_o <= (r_mtime >= r_mtimecmp);
        end
    end

    // Read port: one-cycle latency, data held while no read is returned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= re_i;
            if (re_i) begin
                rdata_o <= w_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_mtimer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_mtimer
//  Description : Self-checking bench for csr_mtimer (CSR_XLEN=32 build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_mtimer;

    logic        clk;
    logic        rst_n;
    logic        en_i;
    logic [7:0]  presc_i;
    logic        we_i;
    logic        re_i;
    logic [1:0]  sel_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        irq_o;
    logic        tick_o;

    int checks   = 0;
    int failures = 0;
    int tick_cnt;

    csr_mtimer #(.CSR_XLEN(32), .CNT_WIDTH(64), .PRESC_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_i),
        .presc_i  (presc_i),
        .we_i     (we_i),
        .re_i     (re_i),
        .sel_i    (sel_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .irq_o    (irq_o),
        .tick_o   (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        we;
        logic        re;
        logic [1:0]  sel;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_irq;
        logic        exp_tick;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [31:0] data);
        we_i = 1'b1; sel_i = sel; wdata_i = data;
        step();
        we_i = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] sel);
        re_i = 1'b1; sel_i = sel;
        step();
        re_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Compare / read-write vectors, starting from mtime=0x1_0000_1234,
        // mtimecmp=all-ones, rdata_o=1 (last read), en=0
        //          en  we  re  sel    wdata         rv  rdata         irq tick
        vecs[0]  = '{0, 1, 0, 2'b10, 32'h0000_0020, 0, 32'h0000_0001, 0, 0};
        vecs[1]  = '{0, 1, 0, 2'b11, 32'h0000_0000, 0, 32'h0000_0001, 0, 0};
        vecs[2]  = '{0, 1, 0, 2'b01, 32'h0000_0000, 0, 32'h0000_0001, 1, 0};
        vecs[3]  = '{0, 1, 0, 2'b00, 32'h0000_001E, 0, 32'h0000_0001, 1, 0};
        vecs[4]  = '{1, 0, 0, 2'b00, 32'h0000_0000, 0, 32'h0000_0001, 0, 1};
        vecs[5]  = '{1, 0, 0, 2'b00, 32'h0000_0000, 0, 32'h0000_0001, 0, 1};
        vecs[6]  = '{1, 0, 0, 2'b00, 32'h0000_0000, 0, 32'h0000_0001, 1, 1};
        vecs[7]  = '{0, 1, 0, 2'b10, 32'h0000_0100, 0, 32'h0000_0001, 1, 0};
        vecs[8]  = '{0, 0, 1, 2'b10, 32'h0000_0000, 1, 32'h0000_0100, 0, 0};
        vecs[9]  = '{0, 1, 1, 2'b00, 32'h0000_0055, 1, 32'h0000_0021, 0, 0};
        vecs[10] = '{0, 0, 1, 2'b00, 32'h0000_0000, 1, 32'h0000_0055, 0, 0};
        vecs[11] = '{0, 0, 0, 2'b00, 32'h0000_0000, 0, 32'h0000_0055, 0, 0};
        vecs[12] = '{0, 0, 1, 2'b11, 32'h0000_0000, 1, 32'h0000_0000, 0, 0};
        vecs[13] = '{0, 1, 0, 2'b10, 32'h0000_0055, 0, 32'h0000_0000, 0, 0};
        vecs[14] = '{0, 0, 0, 2'b00, 32'h0000_0000, 0, 32'h0000_0000, 1, 0};

        rst_n = 1'b0; en_i = 1'b0; presc_i = 8'd0; we_i = 1'b0; re_i = 1'b0;
        sel_i = 2'b00; wdata_i = '0;

        // Reset state
        step();
        step();
        chk("reset_rdata", 64'(rdata_o), 64'h0);
        chk("reset_rvalid", 64'(rvalid_o), 64'h0);
        chk("reset_irq", 64'(irq_o), 64'h0);
        chk("reset_tick", 64'(tick_o), 64'h0);

        // Basic count: presc=0, one tick per enabled cycle
        en_i = 1'b1; presc_i = 8'd0;
        rst_n = 1'b1;
        repeat (10) step();
        do_read(2'b00);
        chk("count_rdata", 64'(rdata_o), 64'd10);
        chk("count_rvalid", 64'(rvalid_o), 64'h1);
        chk("count_tick", 64'(tick_o), 64'h1);
        step();
        chk("count_rvalid_drop", 64'(rvalid_o), 64'h0);
        chk("count_rdata_hold", 64'(rdata_o), 64'd10);

        // Prescaler 3: tick every 4th cycle, mtime=5 after 20 cycles
        en_i = 1'b0;
        do_reset();
        en_i = 1'b1; presc_i = 8'd3;
        tick_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (tick_o) tick_cnt++;
            if (i == 3) chk("presc_no_tick_c3", 64'(tick_o), 64'h0);
            if (i == 4) chk("presc_tick_c4", 64'(tick_o), 64'h1);
        end
        chk("presc_tick_count", 64'(tick_cnt), 64'd5);
        en_i = 1'b0;
        tick_cnt = 0;
        repeat (8) begin
            step();
            if (tick_o) tick_cnt++;
        end
        chk("frozen_tick_count", 64'(tick_cnt), 64'd0);
        do_read(2'b00);
        chk("presc_mtime", 64'(rdata_o), 64'd5);

        // Carry lo -> hi
        presc_i = 8'd0;
        do_write(2'b01, 32'h0000_0000);
        do_write(2'b00, 32'hFFFF_FFFF);
        en_i = 1'b1;
        step();
        chk("carry_tick", 64'(tick_o), 64'h1);
        en_i = 1'b0;
        do_read(2'b00);
        chk("carry_lo", 64'(rdata_o), 64'h0);
        do_read(2'b01);
        chk("carry_hi", 64'(rdata_o), 64'h1);

        // Write on the same cycle as a tick: write wins, no tick pulse
        en_i = 1'b1;
        do_write(2'b00, 32'h0000_1234);
        chk("wr_tick_tick", 64'(tick_o), 64'h0);
        en_i = 1'b0;
        do_read(2'b00);
        chk("wr_tick_lo", 64'(rdata_o), 64'h1234);
        do_read(2'b01);
        chk("wr_tick_hi", 64'(rdata_o), 64'h1);

        // Table: compare, irq timing, read/write interaction
        for (int i = 0; i < 15; i++) begin
            en_i = vecs[i].en; we_i = vecs[i].we; re_i = vecs[i].re;
            sel_i = vecs[i].sel; wdata_i = vecs[i].wdata;
            step();
            chk($sformatf("vec%0d_rvalid", i), 64'(rvalid_o), 64'(vecs[i].exp_rvalid));
            chk($sformatf("vec%0d_rdata", i), 64'(rdata_o), 64'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_irq", i), 64'(irq_o), 64'(vecs[i].exp_irq));
            chk($sformatf("vec%0d_tick", i), 64'(tick_o), 64'(vecs[i].exp_tick));
        end
        en_i = 1'b0; we_i = 1'b0; re_i = 1'b0;

        // Wrap all-ones -> 0 against reset mtimecmp
        do_reset();
        do_write(2'b01, 32'hFFFF_FFFF);
        do_write(2'b00, 32'hFFFF_FFFF);
        step();
        chk("wrap_irq_high", 64'(irq_o), 64'h1);
        en_i = 1'b1;
        step();
        chk("wrap_tick", 64'(tick_o), 64'h1);
        en_i = 1'b0;
        step();
        chk("wrap_irq_low", 64'(irq_o), 64'h0);
        do_read(2'b00);
        chk("wrap_lo", 64'(rdata_o), 64'h0);
        do_read(2'b01);
        chk("wrap_hi", 64'(rdata_o), 64'h0);

        // Hi latch: read lo, tick carries into hi, then read hi
        do_write(2'b01, 32'h0000_0000);
        do_write(2'b00, 32'hFFFF_FFFF);
        do_read(2'b00);
        chk("latch_lo", 64'(rdata_o), 64'hFFFF_FFFF);
        en_i = 1'b1;
        step();
        en_i = 1'b0;
        do_read(2'b01);
`ifdef TIMER_HI_LATCH_EN
        chk("latch_hi", 64'(rdata_o), 64'h0);
`else
        chk("latch_hi", 64'(rdata_o), 64'h1);
`endif

        // Async reset mid-operation
        do_write(2'b11, 32'h0000_0000);
        step();
        en_i = 1'b1; re_i = 1'b1; sel_i = 2'b10;
        step();
        chk("pre_rst_rvalid", 64'(rvalid_o), 64'h1);
        chk("pre_rst_irq", 64'(irq_o), 64'h1);
        chk("pre_rst_rdata", 64'(rdata_o), 64'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rdata", 64'(rdata_o), 64'h0);
        chk("arst_rvalid", 64'(rvalid_o), 64'h0);
        chk("arst_irq", 64'(irq_o), 64'h0);
        chk("arst_tick", 64'(tick_o), 64'h0);
        re_i = 1'b0; en_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
